// File: rtl/register_file_unit.sv
// ---------------------------------------------------------------------------
// register_file_unit
//
// Clocked register unit for the relay-computer datapath. Holds NUM_REGS
// general registers (A, B, C, D, M1, M2, X, Y by default) and exposes
// NUM_PAIRS 16-bit register pairs (M, XY) built from adjacent registers,
// high register at the even offset from PAIR_BASE.
//
// Writes happen on the rising clock edge under sequencer load controls.
// Reads are combinational onto the data bus and address bus, each with an
// output-enable. Bus contention and same-cycle write collisions are
// latched into sticky error flags.
//
// Optional feature (compile-time macro REGFILE_PAIR_INC_EN):
//   Adds the inc_addr port and a per-pair +1 incrementer. Without the macro
//   the port and the incrementer logic do not exist.
//
// Ports:
//   clock          system clock, rising edge active
//   reset          asynchronous, active-high reset
//   ld_data        per-register load from data_in
//   sel_data       per-register data bus drive request
//   ld_addr        per-pair load from addr_in
//   sel_addr       per-pair address bus drive request
//   inc_addr       per-pair increment request (REGFILE_PAIR_INC_EN only)
//   data_in        data bus value to load
//   addr_in        address bus value to load (high:low)
//   clr_err        synchronous clear of the error flags
//   data_out       register at the lowest set sel_data index, else 0
//   data_oe        data bus enable (OR of sel_data)
//   addr_out       pair at the lowest set sel_addr index, else 0
//   addr_oe        address bus enable (OR of sel_addr)
//   err_data_cont  sticky: more than one sel_data bit was high
//   err_addr_cont  sticky: more than one sel_addr bit was high
//   err_wr_coll    sticky: a register was hit by a pair write and ld_data
// ---------------------------------------------------------------------------
module register_file_unit #(
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 8,
  parameter int PAIR_BASE = 4,
  parameter int NUM_PAIRS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REGS-1:0]   ld_data,
  input  logic [NUM_REGS-1:0]   sel_data,
  input  logic [NUM_PAIRS-1:0]  ld_addr,
  input  logic [NUM_PAIRS-1:0]  sel_addr,
`ifdef REGFILE_PAIR_INC_EN
  input  logic [NUM_PAIRS-1:0]  inc_addr,
`endif
  input  logic [DATA_W-1:0]     data_in,
  input  logic [2*DATA_W-1:0]   addr_in,
  input  logic                  clr_err,
  output logic [DATA_W-1:0]     data_out,
  output logic                  data_oe,
  output logic [2*DATA_W-1:0]   addr_out,
  output logic                  addr_oe,
  output logic                  err_data_cont,
  output logic                  err_addr_cont,
  output logic                  err_wr_coll
);

  localparam int PAIR_W = 2 * DATA_W;

  // Current register contents, gathered from the per-register flops
  logic [DATA_W-1:0] reg_val [NUM_REGS];
  // Current pair contents, high:low
  logic [PAIR_W-1:0] pair_val [NUM_PAIRS];
`ifdef REGFILE_PAIR_INC_EN
  // Pair value plus one, wrapping at 2^PAIR_W
  logic [PAIR_W-1:0] pair_next [NUM_PAIRS];
`endif
  // Per-register collision between a pair write and ld_data
  logic [NUM_REGS-1:0] wr_coll;

  // -------------------------------------------------------------------------
  // Pair views of the register array
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_pair_view
    assign pair_val[k] = {reg_val[PAIR_BASE + 2*k], reg_val[PAIR_BASE + 2*k + 1]};
`ifdef REGFILE_PAIR_INC_EN
    assign pair_next[k] = pair_val[k] + PAIR_W'(1);
`endif
  end

  // -------------------------------------------------------------------------
  // Per-register storage and write priority
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam int OFS     = i - PAIR_BASE;
    localparam bit IN_PAIR = (i >= PAIR_BASE) && (i < PAIR_BASE + 2*NUM_PAIRS);

    logic [DATA_W-1:0] val_q;
    logic [DATA_W-1:0] val_d;
    logic              pair_ld;
    logic [DATA_W-1:0] pair_ld_val;
`ifdef REGFILE_PAIR_INC_EN
    logic              pair_inc;
    logic [DATA_W-1:0] pair_inc_val;
`endif

    if (IN_PAIR) begin : g_member
      // Even offset from PAIR_BASE is the high half of the pair
      localparam int K    = OFS / 2;
      localparam bit HIGH = (OFS % 2) == 0;

      assign pair_ld     = ld_addr[K];
      assign pair_ld_val = HIGH ? addr_in[PAIR_W-1:DATA_W] : addr_in[DATA_W-1:0];
`ifdef REGFILE_PAIR_INC_EN
      assign pair_inc     = inc_addr[K];
      assign pair_inc_val = HIGH ? pair_next[K][PAIR_W-1:DATA_W]
                                 : pair_next[K][DATA_W-1:0];
`endif
    end else begin : g_solo
      assign pair_ld     = 1'b0;
      assign pair_ld_val = '0;
`ifdef REGFILE_PAIR_INC_EN
      assign pair_inc     = 1'b0;
      assign pair_inc_val = '0;
`endif
    end

    // Pair load beats increment beats data load; otherwise hold
    always_comb begin
      val_d = val_q;
      if (pair_ld) begin
        val_d = pair_ld_val;
      end
`ifdef REGFILE_PAIR_INC_EN
      else if (pair_inc) begin
        val_d = pair_inc_val;
      end
`endif
      else if (ld_data[i]) begin
        val_d = data_in;
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        val_q <= '0;
      end else begin
        val_q <= val_d;
      end
    end

    assign reg_val[i] = val_q;

`ifdef REGFILE_PAIR_INC_EN
    assign wr_coll[i] = ld_data[i] & (pair_ld | pair_inc);
`else
    assign wr_coll[i] = ld_data[i] & pair_ld;
`endif
  end

  // -------------------------------------------------------------------------
  // Data bus read: lowest set select index wins, scanning downward so the
  // last assignment is the lowest index
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] data_mux;

  always_comb begin
    data_mux = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (sel_data[i]) begin
        data_mux = reg_val[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Address bus read: same lowest-index scheme over the pairs
  // -------------------------------------------------------------------------
  logic [PAIR_W-1:0] addr_mux;

  always_comb begin
    addr_mux = '0;
    for (int k = NUM_PAIRS - 1; k >= 0; k--) begin
      if (sel_addr[k]) begin
        addr_mux = pair_val[k];
      end
    end
  end

  // Outputs are forced quiet while reset is held, whatever the selects say
  assign data_out = reset ? '0 : data_mux;
  assign data_oe  = ~reset & (|sel_data);
  assign addr_out = reset ? '0 : addr_mux;
  assign addr_oe  = ~reset & (|sel_addr);

  // -------------------------------------------------------------------------
  // Error detection. x & (x-1) clears the lowest set bit, so a nonzero
  // result means two or more selects are active.
  // -------------------------------------------------------------------------
  logic data_cont_now;
  logic addr_cont_now;
  logic wr_coll_now;

  assign data_cont_now = |(sel_data & (sel_data - NUM_REGS'(1)));
  assign addr_cont_now = |(sel_addr & (sel_addr - NUM_PAIRS'(1)));
  assign wr_coll_now   = |wr_coll;

  // -------------------------------------------------------------------------
  // Sticky error flags: a fresh error outranks clr_err in the same cycle
  // -------------------------------------------------------------------------
  logic err_data_cont_q, err_data_cont_d;
  logic err_addr_cont_q, err_addr_cont_d;
  logic err_wr_coll_q,   err_wr_coll_d;

  always_comb begin
    err_data_cont_d = data_cont_now | (err_data_cont_q & ~clr_err);
    err_addr_cont_d = addr_cont_now | (err_addr_cont_q & ~clr_err);
    err_wr_coll_d   = wr_coll_now   | (err_wr_coll_q   & ~clr_err);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_data_cont_q <= 1'b0;
      err_addr_cont_q <= 1'b0;
      err_wr_coll_q   <= 1'b0;
    end else begin
      err_data_cont_q <= err_data_cont_d;
      err_addr_cont_q <= err_addr_cont_d;
      err_wr_coll_q   <= err_wr_coll_d;
    end
  end

  assign err_data_cont = err_data_cont_q;
  assign err_addr_cont = err_addr_cont_q;
  assign err_wr_coll   = err_wr_coll_q;

endmodule

// File: tb/tb_register_file_unit.sv
// ---------------------------------------------------------------------------
// tb_register_file_unit
//
// Directed scenarios followed by randomized traffic for register_file_unit
// at its default parameters. A behavioural model holds the eight registers
// as a plain array and applies loads, pair writes and increments in
// ascending priority order, then predicts both buses and the sticky flags.
// Build with REGFILE_PAIR_INC_EN defined to also exercise the incrementer.
// ---------------------------------------------------------------------------
module tb_register_file_unit;

  logic        clock;
  logic        reset;
  logic [7:0]  ld_data;
  logic [7:0]  sel_data;
  logic [1:0]  ld_addr;
  logic [1:0]  sel_addr;
  logic [1:0]  inc_addr;
  logic [7:0]  data_in;
  logic [15:0] addr_in;
  logic        clr_err;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [15:0] addr_out;
  logic        addr_oe;
  logic        err_data_cont;
  logic        err_addr_cont;
  logic        err_wr_coll;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0] m_reg [8];
  logic       m_err_data;
  logic       m_err_addr;
  logic       m_err_coll;

  register_file_unit #(
    .DATA_W(8), .NUM_REGS(8), .PAIR_BASE(4), .NUM_PAIRS(2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ld_data      (ld_data),
    .sel_data     (sel_data),
    .ld_addr      (ld_addr),
    .sel_addr     (sel_addr),
`ifdef REGFILE_PAIR_INC_EN
    .inc_addr     (inc_addr),
`endif
    .data_in      (data_in),
    .addr_in      (addr_in),
    .clr_err      (clr_err),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .addr_out     (addr_out),
    .addr_oe      (addr_oe),
    .err_data_cont(err_data_cont),
    .err_addr_cont(err_addr_cont),
    .err_wr_coll  (err_wr_coll)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and on mismatch counts and reports the failure
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_err_data = 1'b0;
    m_err_addr = 1'b0;
    m_err_coll = 1'b0;
  endtask

  // Compare every output against what the model predicts for the present inputs
  task automatic compareModel();
    logic [7:0]  exp_data;
    logic [15:0] exp_addr;
    exp_data = 8'h00;
    exp_addr = 16'h0000;
    for (int i = 7; i >= 0; i--)
      if (sel_data[i]) exp_data = m_reg[i];
    for (int k = 1; k >= 0; k--)
      if (sel_addr[k]) exp_addr = {m_reg[4 + 2*k], m_reg[5 + 2*k]};
    if (reset) begin
      exp_data = 8'h00;
      exp_addr = 16'h0000;
    end
    checkOutput("data_out", {8'h00, data_out}, {8'h00, exp_data});
    checkOutput("data_oe", {15'h0, data_oe}, {15'h0, (!reset && sel_data != 8'h00)});
    checkOutput("addr_out", addr_out, exp_addr);
    checkOutput("addr_oe", {15'h0, addr_oe}, {15'h0, (!reset && sel_addr != 2'b00)});
    checkOutput("err_data_cont", {15'h0, err_data_cont}, {15'h0, m_err_data});
    checkOutput("err_addr_cont", {15'h0, err_addr_cont}, {15'h0, m_err_addr});
    checkOutput("err_wr_coll", {15'h0, err_wr_coll}, {15'h0, m_err_coll});
  endtask

  // Drive one cycle's inputs after the falling edge, then check the outputs
  task automatic applyStimulus(input logic [7:0] ld_d, input logic [7:0] sel_d,
                               input logic [1:0] ld_a, input logic [1:0] sel_a,
                               input logic [7:0] din, input logic [15:0] ain,
                               input logic clr, input logic [1:0] inc);
    @(negedge clock);
    ld_data  = ld_d;
    sel_data = sel_d;
    ld_addr  = ld_a;
    sel_addr = sel_a;
    data_in  = din;
    addr_in  = ain;
    clr_err  = clr;
    inc_addr = inc;
    #1;
    compareModel();
  endtask

  // Advance the model across the rising edge using the inputs now applied
  task automatic clockEdge();
    logic [7:0]  nxt [8];
    logic [15:0] pv;
    logic        coll;
    @(posedge clock);
    if (reset) begin
      modelClear();
    end else begin
      nxt  = m_reg;
      coll = 1'b0;
      for (int i = 0; i < 8; i++)
        if (ld_data[i]) nxt[i] = data_in;
      for (int k = 0; k < 2; k++) begin
        pv = {m_reg[4 + 2*k], m_reg[5 + 2*k]};
        if (ld_addr[k])       {nxt[4 + 2*k], nxt[5 + 2*k]} = addr_in;
        else if (inc_addr[k]) {nxt[4 + 2*k], nxt[5 + 2*k]} = pv + 16'd1;
        if ((ld_addr[k] || inc_addr[k]) && (ld_data[4 + 2*k] || ld_data[5 + 2*k]))
          coll = 1'b1;
      end
      m_err_data = ($countones(sel_data) > 1) || (m_err_data && !clr_err);
      m_err_addr = ($countones(sel_addr) > 1) || (m_err_addr && !clr_err);
      m_err_coll = coll || (m_err_coll && !clr_err);
      m_reg = nxt;
    end
  endtask

  initial begin
    logic [7:0] r_ld;
    logic [7:0] r_sel;
    logic [1:0] r_lda;
    logic [1:0] r_sela;
    logic [1:0] r_inc;

    reset    = 1'b1;
    ld_data  = '0;
    sel_data = '0;
    ld_addr  = '0;
    sel_addr = '0;
    inc_addr = '0;
    data_in  = '0;
    addr_in  = '0;
    clr_err  = 1'b0;
    modelClear();

    // Power-on reset state
    #1;
    compareModel();
    @(negedge clock);
    reset = 1'b0;
    clockEdge();

    // Reset asserted mid-operation with A selected on the data bus
    applyStimulus(8'h01, 8'h00, 2'b00, 2'b00, 8'h5A, 16'h0000, 1'b0, 2'b00);
    clockEdge();
    applyStimulus(8'h00, 8'h01, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 2'b00);
    checkOutput("pre_rst_A", {8'h00, data_out}, 16'h005A);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_data_out", {8'h00, data_out}, 16'h0000);
    checkOutput("rst_data_oe", {15'h0, data_oe}, 16'h0000);
    modelClear();
    clockEdge();
    @(negedge clock);
    reset = 1'b0;
    clockEdge();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'h00, 8'(1 << i), 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 2'b00);
      checkOutput("post_rst_reg", {8'h00, data_out}, 16'h0000);
      clockEdge();
    end

    // Load B, same-cycle select sees the old value
    applyStimulus(8'h02, 8'h02, 2'b00, 2'b00, 8'h3C, 16'h0000, 1'b0, 2'b00);
    checkOutput("same_cycle_old", {8'h00, data_out}, 16'h0000);
    clockEdge();
    applyStimulus(8'h00, 8'h02, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 2'b00);
    checkOutput("B_loaded", {8'h00, data_out}, 16'h003C);
    checkOutput("B_oe", {15'h0, data_oe}, 16'h0001);
    clockEdge();

    // Pair load of XY, read halves and the pair
    applyStimulus(8'h00, 8'h00, 2'b10, 2'b00, 8'h00, 16'hBEEF, 1'b0, 2'b00);
    clockEdge();
    applyStimulus(8'h00, 8'h40, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 2'b00);
    checkOutput("X_half", {8'h00, data_out}, 16'h00BE);
    clockEdge();
    applyStimulus(8'h00, 8'h80, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 2'b00);
    checkOutput("Y_half", {8'h00, data_out}, 16'h00EF);
    clockEdge();
    applyStimulus(8'h00, 8'h00, 2'b00, 2'b10, 8'h00, 16'h0000, 1'b0, 2'b00);
    checkOutput("XY_pair", addr_out, 16'hBEEF);
    clockEdge();

    // Data bus contention and sticky flag behaviour
    applyStimulus(8'h01, 8'h00, 2'b00, 2'b00, 8'h11, 16'h0000, 1'b0, 2'b00);
    clockEdge();
    applyStimulus(8'h04, 8'h00, 2'b00, 2'b00, 8'h22, 16'h0000, 1'b0, 2'b00);
    clockEdge();
    applyStimulus(8'h00, 8'h05, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 2'b00);
    checkOutput("cont_lowest", {8'h00, data_out}, 16'h0011);
    clockEdge();
    applyStimulus(8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 2'b00);
    checkOutput("cont_set", {15'h0, err_data_cont}, 16'h0001);
    clockEdge();
    applyStimulus(8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b1, 2'b00);
    checkOutput("cont_sticky", {15'h0, err_data_cont}, 16'h0001);
    clockEdge();
    applyStimulus(8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 2'b00);
    checkOutput("cont_cleared", {15'h0, err_data_cont}, 16'h0000);
    clockEdge();

    // Clear with a fresh contention in the same cycle keeps the flag set
    applyStimulus(8'h00, 8'h00, 2'b00, 2'b11, 8'h00, 16'h0000, 1'b1, 2'b00);
    clockEdge();
    applyStimulus(8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b1, 2'b00);
    checkOutput("addr_cont_new_wins", {15'h0, err_addr_cont}, 16'h0001);
    clockEdge();

    // Pair load and data load on M1 in one cycle: pair wins, collision flagged
    applyStimulus(8'h10, 8'h00, 2'b01, 2'b00, 8'hAA, 16'h1234, 1'b0, 2'b00);
    clockEdge();
    applyStimulus(8'h00, 8'h10, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 2'b00);
    checkOutput("M1_pair_wins", {8'h00, data_out}, 16'h0012);
    checkOutput("coll_set", {15'h0, err_wr_coll}, 16'h0001);
    clockEdge();
    applyStimulus(8'h00, 8'h20, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 2'b00);
    checkOutput("M2_pair", {8'h00, data_out}, 16'h0034);
    clockEdge();
    applyStimulus(8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b1, 2'b00);
    clockEdge();

`ifdef REGFILE_PAIR_INC_EN
    // Increment wraps, and a pair load overrides a simultaneous increment
    applyStimulus(8'h00, 8'h00, 2'b10, 2'b00, 8'h00, 16'hFFFF, 1'b0, 2'b00);
    clockEdge();
    applyStimulus(8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 2'b10);
    clockEdge();
    applyStimulus(8'h00, 8'h00, 2'b00, 2'b10, 8'h00, 16'h0000, 1'b0, 2'b00);
    checkOutput("inc_wrap", addr_out, 16'h0000);
    clockEdge();
    applyStimulus(8'h00, 8'h00, 2'b10, 2'b00, 8'h00, 16'h0100, 1'b0, 2'b10);
    clockEdge();
    applyStimulus(8'h00, 8'h00, 2'b00, 2'b10, 8'h00, 16'h0000, 1'b0, 2'b00);
    checkOutput("ld_over_inc", addr_out, 16'h0100);
    clockEdge();
    // Increment with ld_data on X: increment wins, collision flagged
    applyStimulus(8'h40, 8'h00, 2'b00, 2'b00, 8'h77, 16'h0000, 1'b1, 2'b10);
    clockEdge();
    applyStimulus(8'h00, 8'h00, 2'b00, 2'b10, 8'h00, 16'h0000, 1'b0, 2'b00);
    checkOutput("inc_over_ld", addr_out, 16'h0101);
    checkOutput("inc_coll", {15'h0, err_wr_coll}, 16'h0001);
    clockEdge();
`endif

    // Randomized traffic checked against the model every cycle
    for (int n = 0; n < 300; n++) begin
      r_ld   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      r_lda  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      case ($urandom_range(0, 2))
        0:       r_sel = 8'h00;
        1:       r_sel = 8'(1 << $urandom_range(0, 7));
        default: r_sel = 8'($urandom);
      endcase
      r_sela = 2'($urandom);
`ifdef REGFILE_PAIR_INC_EN
      r_inc  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
`else
      r_inc  = 2'b00;
`endif
      applyStimulus(r_ld, r_sel, r_lda, r_sela, 8'($urandom), 16'($urandom),
                    ($urandom_range(0, 7) == 0), r_inc);
      clockEdge();
    end

    // Final state check with everything idle
    applyStimulus(8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_unit.md
Name: register_file_unit

Overview:
- Parametrised, clocked successor to the relay-computer register unit: NUM_REGS general registers of DATA_W bits, plus NUM_PAIRS 16-bit register pairs (M, XY style) formed from adjacent registers.
- Sequencer load/select controls drive writes on the clock edge. Reads are combinational onto data-bus and address-bus output/enable pairs.
- Detects multi-driver bus contention and same-cycle write collisions, and reports them through sticky error flags.

Parameters:
- DATA_W, 8, width of each register and of the data bus.
- NUM_REGS, 8, number of general registers. Index 0..7 maps to A, B, C, D, M1, M2, X, Y.
- PAIR_BASE, 4, index of the first register used by pairs.
- NUM_PAIRS, 2, number of pairs. Pair k = {reg[PAIR_BASE+2k] (high), reg[PAIR_BASE+2k+1] (low)}. Requires PAIR_BASE+2*NUM_PAIRS <= NUM_REGS.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ld_data  in  NUM_REGS  per-register load from data_in.
- sel_data  in  NUM_REGS  per-register drive request for the data bus.
- ld_addr  in  NUM_PAIRS  per-pair load from addr_in.
- sel_addr  in  NUM_PAIRS  per-pair drive request for the address bus.
- data_in  in  DATA_W  data bus value to be loaded.
- addr_in  in  2*DATA_W  address bus value to be loaded.
- data_out  out  DATA_W  selected register value.
- data_oe  out  1  data bus enable.
- addr_out  out  2*DATA_W  selected pair value.
- addr_oe  out  1  address bus enable.
- clr_err  in  1  synchronous clear of the error flags.
- err_data_cont  out  1  sticky flag: more than one sel_data bit was high.
- err_addr_cont  out  1  sticky flag: more than one sel_addr bit was high.
- err_wr_coll  out  1  sticky flag: a register was targeted by both ld_data and ld_addr in the same cycle.
- inc_addr  in  NUM_PAIRS  per-pair increment request. Present only with PAIR_INC_EN.

Behaviour:
- Reset:
  - All registers go to 0 and all error flags go to 0, asynchronously.
  - While reset is high, data_out=0, addr_out=0, data_oe=0, addr_oe=0, regardless of the select inputs.
- Writes:
  - Registers update at the rising edge only. data_out and addr_out reflect the new value from the next cycle.
  - A load and a select of the same register in the same cycle reads the old value.
- Write priority per register, highest first:
  1. ld_addr covering that register.
  2. inc_addr, if the feature is compiled in.
  3. ld_data.
  4. Hold.
- Write collision:
  - If ld_addr and ld_data target the same register in one cycle, the pair load wins and err_wr_coll is set at that edge.
  - Several ld_data bits may be high together; every addressed register loads the same data_in. This is legal.
  - Several ld_addr bits may be high together; every addressed pair loads addr_in. This is legal.
- Data bus read:
  - data_oe = OR of sel_data.
  - data_out = register at the lowest set index of sel_data, or 0 when none is set.
  - If popcount(sel_data) > 1, err_data_cont is set at the next edge.
- Address bus read:
  - Same scheme as the data bus, using sel_addr, addr_out, addr_oe and err_addr_cont.
  - Pairs concatenate high:low.
- Error flags:
  - Sticky until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the new error wins and the flag stays 1.
- Reset deasserted between edges: first writes occur at the next rising edge. No partial writes.
- No internal FSM beyond per-register state and error flags. Implementation uses generate loops over NUM_REGS and NUM_PAIRS.

Optional Feature:
- Macro: REGFILE_PAIR_INC_EN.
- With the macro defined:
  - The inc_addr port exists.
  - inc_addr[k] writes pair k + 1, modulo 2^(2*DATA_W), at the edge. 16'hFFFF wraps to 16'h0000 with no carry out.
  - ld_addr[k] overrides inc_addr[k].
  - inc_addr[k] together with ld_data on a register of pair k sets err_wr_coll, and the increment wins.
- Without the macro: no inc_addr port and no incrementer logic. Pairs change only through ld_addr or ld_data.

Test Plan:
1. Assert reset mid-operation with A=8'h5A and sel_data[0]=1 -> data_out=0 and data_oe=0 immediately. After release, all registers read 0.
2. data_in=8'h3C with ld_data[1]=1 for one cycle, then sel_data[1]=1 -> data_out=8'h3C and data_oe=1 from the cycle after the load. Same-cycle select returns the old value 0.
3. addr_in=16'hBEEF with ld_addr[1]=1, then sel_data[6]=1 and next sel_data[7]=1 -> X=8'hBE, Y=8'hEF. sel_addr[1]=1 -> addr_out=16'hBEEF.
4. sel_data=8'b0000_0101 with A=8'h11, C=8'h22 -> data_out=8'h11 and err_data_cont=1 next cycle. The flag persists until clr_err, then returns to 0.
5. In one cycle: ld_addr[0]=1 with addr_in=16'h1234, ld_data[4]=1 with data_in=8'hAA -> M1=8'h12, M2=8'h34, err_wr_coll=1.
6. With REGFILE_PAIR_INC_EN, XY=16'hFFFF, inc_addr[1]=1 for one cycle -> XY=16'h0000. Then inc_addr[1]=1 and ld_addr[1]=1 with addr_in=16'h0100 -> XY=16'h0100.
